// File: rtl/load_scoreboard.sv
// Load-use scoreboard: tracks destination registers of loads that have issued
// but whose data has not yet returned. Decode is stalled while it would read one
// of them, or while it issues a load and no tag slot is free.
module load_scoreboard #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic        issue_is_load,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_rg,
  input  logic [4:0]  rs2_rg,
  input  logic [1:0]  rs_use,
  input  logic        rsp_valid,
  output logic        stall,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic [15:0] stall_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   pending;
  logic [31:0]   pending_next;
  logic [4:0]    tags [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          empty;
  logic          full;
  logic [4:0]    head_tag;
  logic          younger_match;
  logic          push;
  logic          pop;
  logic          hazard_rs1;
  logic          hazard_rs2;

  assign wr_idx   = wr_ptr[AW-1:0];
  assign rd_idx   = rd_ptr[AW-1:0];
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign head_tag = tags[rd_idx];

  // Operand hazards against pending registers; x0 is never a hazard.
  always_comb begin
    hazard_rs1 = rs_use[0] && (rs1_rg != 5'd0) && pending[rs1_rg];
    hazard_rs2 = rs_use[1] && (rs2_rg != 5'd0) && pending[rs2_rg];
  end

  // Stall uses registered state only, so a same-cycle response cannot release it.
  always_comb begin
    stall = hazard_rs1 || hazard_rs2 || (full && issue_is_load);
  end

  // Handshake qualifiers for the tag FIFO.
  always_comb begin
    push = issue_valid && issue_is_load && !stall;
    pop  = rsp_valid && !empty;
  end

  // Write-back tag of the oldest outstanding load, zero when nothing is outstanding.
  always_comb begin
    rsp_rd = empty ? 5'd0 : head_tag;
  end

  // Search the entries behind the head for another load to the same register.
  always_comb begin
    logic [AW-1:0] idx;
    younger_match = 1'b0;
    idx           = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      idx = rd_idx + AW'(i);
      if (((AW+1)'(i) < count) && (tags[idx] == head_tag))
        younger_match = 1'b1;
    end
  end

  // Next pending vector: retire the head unless the register is still owed, then mark a new load.
  always_comb begin
    pending_next = pending;
    if (pop && !younger_match && !(push && (issue_rd == head_tag)))
      pending_next[head_tag] = 1'b0;
    if (push)
      pending_next[issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // Pending register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= '0;
    else
      pending <= pending_next;
  end

  // Tag FIFO pointers, wrapping modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Tag FIFO storage; contents are don't-care outside the pointer window.
  always_ff @(posedge clk) begin
    if (push)
      tags[wr_idx] <= issue_rd;
  end

  // Sticky flag for a response with no outstanding load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rsp_err <= 1'b0;
    else if (rsp_valid && empty)
      rsp_err <= 1'b1;
  end

  // Saturating stalled-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_load_scoreboard.sv
// Testbench for load_scoreboard: directed scenarios plus random traffic, checked
// against a queue-of-outstanding-loads reference model through a scoreboard.
module tb_load_scoreboard;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_is_load = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  rs1_rg = '0;
  logic [4:0]  rs2_rg = '0;
  logic [1:0]  rs_use = '0;
  logic        rsp_valid = 1'b0;
  logic        stall;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic [15:0] stall_cnt;

  load_scoreboard #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_is_load(issue_is_load),
    .issue_rd(issue_rd), .rs1_rg(rs1_rg), .rs2_rg(rs2_rg), .rs_use(rs_use),
    .rsp_valid(rsp_valid), .stall(stall), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [4:0]  rd;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t        expq[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: outstanding loads in issue order; a register is pending
  // exactly when it is nonzero and still appears among the outstanding loads.
  logic [4:0]  mq[$];
  logic        m_err = 1'b0;
  int unsigned m_cnt = 0;

  function automatic logic owed(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive inputs, queue the expected outputs, advance the model.
  task automatic step(input logic r, input logic v, input logic l, input logic [4:0] rd,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [1:0] u,
                      input logic rsp);
    exp_t e;
    logic st;
    @(negedge clk);
    rst_n = r; issue_valid = v; issue_is_load = l; issue_rd = rd;
    rs1_rg = s1; rs2_rg = s2; rs_use = u; rsp_valid = rsp;
    if (!r) begin
      mq.delete(); m_err = 1'b0; m_cnt = 0;
      e.stall = 1'b0; e.rd = '0; e.err = 1'b0; e.cnt = '0;
      expq.push_back(e);
    end else begin
      st = (u[0] && owed(s1)) || (u[1] && owed(s2)) || ((mq.size() == DEPTH) && l);
      e.stall = st;
      e.rd    = (mq.size() == 0) ? 5'd0 : mq[0];
      e.err   = m_err;
      e.cnt   = m_cnt[15:0];
      expq.push_back(e);
      if (rsp && mq.size() == 0) m_err = 1'b1;
      if (st && m_cnt < 65535) m_cnt++;
      if (rsp && mq.size() > 0) void'(mq.pop_front());
      if (v && l && !st) mq.push_back(rd);
    end
  endtask

  task automatic idle(input logic rsp);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, rsp);
  endtask

  task automatic load(input logic [4:0] rd, input logic rsp);
    step(1'b1, 1'b1, 1'b1, rd, 5'd0, 5'd0, 2'b00, rsp);
  endtask

  task automatic branch(input logic [4:0] s1, input logic [4:0] s2, input logic [1:0] u,
                        input logic rsp);
    step(1'b1, 1'b1, 1'b0, 5'd0, s1, s2, u, rsp);
  endtask

  // Monitor: outputs are valid every cycle; compare after inputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("stall", stall, e.stall);
        check("rsp_rd", rsp_rd, e.rd);
        check("rsp_err", rsp_err, e.err);
        check("stall_cnt", stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    // Reset state, then first-edge acceptance.
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 2'b00, 1'b1);
    idle(1'b0);

    // Load-use hazard on rs1 released the cycle after the response.
    load(5'd5, 1'b0);
    repeat (3) branch(5'd5, 5'd0, 2'b01, 1'b0);
    branch(5'd5, 5'd0, 2'b01, 1'b1);
    branch(5'd5, 5'd0, 2'b01, 1'b0);
    idle(1'b0);

    // Full FIFO refuses a load, even alongside a pop; accepted next cycle.
    load(5'd1, 1'b0); load(5'd2, 1'b0); load(5'd3, 1'b0); load(5'd4, 1'b0);
    load(5'd6, 1'b0);
    load(5'd6, 1'b1);
    load(5'd6, 1'b0);
    repeat (5) idle(1'b1);

    // Duplicate tag stays pending until its last load returns.
    load(5'd7, 1'b0); load(5'd7, 1'b0);
    branch(5'd0, 5'd7, 2'b10, 1'b1);
    branch(5'd0, 5'd7, 2'b10, 1'b0);
    branch(5'd0, 5'd7, 2'b10, 1'b1);
    branch(5'd0, 5'd7, 2'b10, 1'b0);
    // Unused operand does not stall; non-load issue leaves state alone.
    step(1'b1, 1'b1, 1'b0, 5'd12, 5'd12, 5'd12, 2'b00, 1'b0);
    branch(5'd12, 5'd12, 2'b11, 1'b0);

    // Load to x0 occupies a slot but never stalls.
    load(5'd0, 1'b0);
    branch(5'd0, 5'd0, 2'b11, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Spurious response, reset mid-stall, then a response with nothing outstanding.
    idle(1'b1);
    idle(1'b0);
    load(5'd9, 1'b0);
    repeat (3) branch(5'd9, 5'd0, 2'b01, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd0, 5'd9, 5'd0, 2'b01, 1'b0);
    branch(5'd9, 5'd0, 2'b01, 1'b1);
    idle(1'b0);

    // Counter saturation under a long stall.
    load(5'd3, 1'b0);
    repeat (70000) branch(5'd3, 5'd0, 2'b01, 1'b0);
    branch(5'd3, 5'd0, 2'b01, 1'b1);
    branch(5'd3, 5'd0, 2'b01, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);

    // Random traffic over a small register range to provoke hazards and duplicates.
    repeat (3000) begin
      step(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 4));
    end

    repeat (2) @(negedge clk);
    #3;
    check("scoreboard_drain", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
